// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg
// Shared constants for the byte/frame FIFO family. The byte-to-frame packer
// and the frame-to-byte unpacker both take their widths from here, so the
// two sides always agree on the frame layout.
//   FRAME_BYTES_DEF : default bytes per frame
//   BYTE_W          : width of one byte lane
//   FRAME_W         : default frame width (FRAME_BYTES_DEF * BYTE_W)
//   DEPTH_DEF       : default number of buffered frames
package byte_fifo_pkg;

  localparam int FRAME_BYTES_DEF = 15;
  localparam int BYTE_W          = 8;
  localparam int FRAME_W         = FRAME_BYTES_DEF * BYTE_W;
  localparam int DEPTH_DEF       = 2;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/byte_unpack_fifo_frame_ram.sv
// frame_ram
// Frame storage for the unpacking FIFO: DEPTH entries of WIDTH bits, written
// synchronously and read combinationally by pointer. It has no reset because
// an entry is never read before it has been written.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : entry to write
//   wdata : frame to store
//   raddr : entry to read
//   rdata : frame at raddr (combinational)
module frame_ram
  import byte_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = FRAME_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/byte_unpack_fifo.sv
// byte_unpack_fifo
// Buffers whole frames and hands them out one byte at a time, byte 0
// (the least significant byte) first. A frame keeps its slot until its last
// byte has been popped, so a write while full can never disturb the frame
// currently being read.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   wdata  : frame to buffer
//   winc   : frame write request
//   rinc   : byte read request
//   rdata  : byte popped on the previous cycle (held when nothing is popped)
//   rvalid : rdata was updated by a pop on the previous cycle
//   full   : DEPTH frames resident
//   empty  : no unread bytes
//   ovf    : sticky, a write was dropped because the FIFO was full
//   udf    : sticky, a read was dropped because the FIFO was empty
module byte_unpack_fifo
  import byte_fifo_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W*FRAME_BYTES-1:0] wdata,
  input  logic                          winc,
  input  logic                          rinc,
  output logic [BYTE_W-1:0]             rdata,
  output logic                          rvalid,
  output logic                          full,
  output logic                          empty,
  output logic                          ovf,
  output logic                          udf
);

  localparam int FW = BYTE_W * FRAME_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [BW-1:0]     bidx;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [FW-1:0]     rd_frame;
  logic [BYTE_W-1:0] byte_sel;
  logic              wr_acc;
  logic              rd_acc;
  logic              last_pop;

  // full/empty are registered copies of the frame count, so acceptance is
  // decided purely from the state at the start of the cycle.
  assign wr_acc   = winc && !full;
  assign rd_acc   = rinc && !empty;
  assign last_pop = rd_acc && (bidx == LAST_BYTE);

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .AW    (AW)
  ) u_frame_ram (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rd_frame)
  );

  // Byte lane mux on bidx; the stored frame itself is never shifted.
  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (bidx == BW'(k)) begin
        byte_sel = rd_frame[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // A frame enters on an accepted write and leaves only when its last byte
  // is popped; both in one cycle cancel out.
  always_comb begin
    count_next = count;
    unique case ({wr_acc, last_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      bidx   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdata  <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end

      if (rd_acc) begin
        rdata  <= byte_sel;
        rvalid <= 1'b1;
        if (last_pop) begin
          bidx <= '0;
          rptr <= rptr + 1'b1;
        end else begin
          bidx <= bidx + 1'b1;
        end
      end else begin
        rvalid <= 1'b0;
      end

      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);

      if (winc && full) begin
        ovf <= 1'b1;
      end
      if (rinc && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_unpack_fifo.sv
// tb_byte_unpack_fifo
// Directed bench for byte_unpack_fifo. A queue-of-frames model tracks what
// the FIFO must hold and emit; a negedge process compares every output to it
// each cycle, and the stimulus sequence adds literal expectations.
module tb_byte_unpack_fifo;
  import byte_fifo_pkg::*;

  localparam int FB    = FRAME_BYTES_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic               clk = 1'b0;
  logic               rst;
  logic [FRAME_W-1:0] wdata;
  logic               winc;
  logic               rinc;
  logic [BYTE_W-1:0]  rdata;
  logic               rvalid;
  logic               full;
  logic               empty;
  logic               ovf;
  logic               udf;

  int checks = 0;
  int errors = 0;

  byte_unpack_fifo #(
    .FRAME_BYTES (FB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .rvalid (rvalid),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .udf    (udf)
  );

  always #5 clk = ~clk;

  // Model: resident frames in arrival order, plus how far into the oldest
  // one the reader has got.
  logic [FRAME_W-1:0] m_frames [$];
  int                 m_bidx   = 0;
  logic [7:0]         m_rdata  = 8'h00;
  logic               m_rvalid = 1'b0;
  logic               m_ovf    = 1'b0;
  logic               m_udf    = 1'b0;
  bit                 chk_en   = 1'b0;

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] base);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < FB; k++) begin
      f[k*8 +: 8] = base + 8'(k);
    end
    return f;
  endfunction

  // Decisions use the occupancy before the edge: a drop while full stays a
  // drop even if the same edge frees a slot, likewise for reads while empty.
  always @(posedge clk) begin
    logic [FRAME_W-1:0] f;
    bit was_full;
    bit was_empty;
    if (rst) begin
      m_frames.delete();
      m_bidx   = 0;
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      was_full  = (m_frames.size() == DEPTH);
      was_empty = (m_frames.size() == 0);
      if (rinc && !was_empty) begin
        f        = m_frames[0];
        m_rdata  = f[m_bidx*8 +: 8];
        m_rvalid = 1'b1;
        m_bidx++;
        if (m_bidx == FB) begin
          m_bidx = 0;
          void'(m_frames.pop_front());
        end
      end else begin
        m_rvalid = 1'b0;
        if (rinc) m_udf = 1'b1;
      end
      if (winc) begin
        if (was_full) m_ovf = 1'b1;
        else          m_frames.push_back(wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model rdata",  32'(rdata),  32'(m_rdata));
      check_output("model rvalid", 32'(rvalid), 32'(m_rvalid));
      check_output("model full",   32'(full),   32'(m_frames.size() == DEPTH));
      check_output("model empty",  32'(empty),  32'(m_frames.size() == 0));
      check_output("model ovf",    32'(ovf),    32'(m_ovf));
      check_output("model udf",    32'(udf),    32'(m_udf));
    end
  end

  // Drives one cycle of inputs and returns at the following negedge.
  task automatic apply_stimulus(input logic r, input logic w, input logic rd,
                                input logic [FRAME_W-1:0] d);
    rst   = r;
    winc  = w;
    rinc  = rd;
    wdata = d;
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;

    $display("[TB] reset values");
    check_output("rst rdata",  32'(rdata),  32'h00);
    check_output("rst rvalid", 32'(rvalid), 32'h0);
    check_output("rst full",   32'(full),   32'h0);
    check_output("rst empty",  32'(empty),  32'h1);
    check_output("rst ovf",    32'(ovf),    32'h0);
    check_output("rst udf",    32'(udf),    32'h0);

    $display("[TB] read while empty");
    apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    check_output("udf rvalid", 32'(rvalid), 32'h0);
    check_output("udf rdata",  32'(rdata),  32'h00);
    check_output("udf set",    32'(udf),    32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("udf cleared by rst", 32'(udf), 32'h0);

    $display("[TB] single frame 01..0F");
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h01));
    check_output("one frame empty", 32'(empty), 32'h0);
    for (int k = 0; k < FB; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      check_output("seq rdata",  32'(rdata),  32'(k + 1));
      check_output("seq rvalid", 32'(rvalid), 32'h1);
    end
    check_output("seq empty after last", 32'(empty), 32'h1);
    apply_stimulus(1'b0, 1'b0, 0, '0);
    check_output("idle rvalid", 32'(rvalid), 32'h0);
    check_output("idle rdata hold", 32'(rdata), 32'h0F);

    $display("[TB] two frames, overflow, read back");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h10));
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h20));
    check_output("AB full", 32'(full), 32'h1);
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h30));
    check_output("AB ovf", 32'(ovf), 32'h1);
    for (int i = 0; i < 2*FB; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      check_output("AB rdata", 32'(rdata),
                   (i < FB) ? 32'(8'h10 + i) : 32'(8'h20 + i - FB));
    end
    check_output("AB empty", 32'(empty), 32'h1);

    $display("[TB] last-byte pop with write while full");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h10));
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h20));
    for (int i = 0; i < FB - 1; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b1, make_frame(8'h30));
    check_output("pop14 rdata", 32'(rdata), 32'h1E);
    check_output("pop14 ovf",   32'(ovf),   32'h1);
    check_output("pop14 full",  32'(full),  32'h0);
    check_output("pop14 empty", 32'(empty), 32'h0);
    for (int i = 0; i < FB; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      check_output("pop14 B rdata", 32'(rdata), 32'(8'h20 + i));
    end
    check_output("pop14 C dropped", 32'(empty), 32'h1);

    $display("[TB] write/read passes with pointer wrap");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b1, make_frame(8'h90));
    check_output("wr+rd empty udf",    32'(udf),    32'h1);
    check_output("wr+rd empty rvalid", 32'(rvalid), 32'h0);
    check_output("wr+rd empty wrote",  32'(empty),  32'h0);
    for (int i = 0; i < FB; i++) apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'(8'h40 + 16*p)));
      check_output("pass full", 32'(full), 32'h0);
      for (int i = 0; i < FB; i++) begin
        apply_stimulus(1'b0, 1'b0, 1'b1, '0);
        check_output("pass rdata", 32'(rdata), 32'(8'h40 + 16*p + i));
      end
      check_output("pass empty", 32'(empty), 32'h1);
    end

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h70));
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    check_output("pre-rst rdata", 32'(rdata), 32'h77);
    apply_stimulus(1'b1, 1'b1, 1'b1, make_frame(8'hA0));
    check_output("mid rst empty",  32'(empty),  32'h1);
    check_output("mid rst rvalid", 32'(rvalid), 32'h0);
    check_output("mid rst full",   32'(full),   32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, make_frame(8'h80));
    apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    check_output("post rst rdata",  32'(rdata),  32'h80);
    check_output("post rst rvalid", 32'(rvalid), 32'h1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_unpack_fifo.md
BYTE_UNPACK_FIFO -- requirements
Module: byte_unpack_fifo

Interface
REQ-001 Parameter FRAME_BYTES, default 15, bytes per frame; the frame width is 8*FRAME_BYTES = 120.
REQ-002 Parameter DEPTH, default 2, frames buffered; power of two, >= 2.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wdata, input, 120 bits: frame to buffer.
REQ-006 Port winc, input, 1 bit: frame write request.
REQ-007 Port rinc, input, 1 bit: byte read request.
REQ-008 Port rdata, output, 8 bits: byte read out.
REQ-009 Port rvalid, output, 1 bit: rdata holds a byte popped last cycle.
REQ-010 Port full, output, 1 bit: DEPTH frames held.
REQ-011 Port empty, output, 1 bit: no unread bytes.
REQ-012 Port ovf, output, 1 bit: sticky, a write was dropped.
REQ-013 Port udf, output, 1 bit: sticky, a read was dropped.

Function
REQ-014 A write is accepted on a clk edge with winc=1 and full=0; the whole frame is stored at wptr and wptr advances modulo DEPTH.
REQ-015 A read is accepted on a clk edge with rinc=1 and empty=0; byte bidx of frame rptr goes to rdata, rvalid=1 on the next cycle, so read latency is 1 cycle.
REQ-016 Byte order is LSB first: byte k = wdata[8k+7:8k], so byte 0 is output first.
REQ-017 bidx counts 0..FRAME_BYTES-1; after popping byte FRAME_BYTES-1, bidx returns to 0 and rptr advances modulo DEPTH.
REQ-018 A frame counter (0..DEPTH) increments on each accepted write and decrements on each completed frame (last-byte pop); when both occur in one cycle it is unchanged.
REQ-019 full = (count==DEPTH); empty = (count==0); both are registered and reflect state at the start of the cycle.
REQ-020 winc while full: the write is dropped, storage is unchanged and ovf sets, even if the last-byte pop of the same cycle frees a slot.
REQ-021 rinc while empty: the read is dropped, rvalid=0 next cycle and udf sets, even if a write is accepted in the same cycle.
REQ-022 When no read is accepted, rvalid=0 next cycle and rdata holds its previous value.
REQ-023 A partially read frame stays resident: a write while full never overwrites the frame at rptr.
REQ-024 Pointers wrap: after DEPTH frames written and read, wptr=rptr=0 again.

Reset
REQ-025 Reset values: rdata=8'h00, rvalid=0, full=0, empty=1, ovf=0, udf=0, wptr=rptr=0, bidx=0, count=0.
REQ-026 Reset asserted mid-frame discards all buffered data, and winc/rinc are ignored in the reset cycle.
REQ-027 Frame storage is not reset; it is unobservable until written.
REQ-028 ovf and udf clear only on reset.

Structure
REQ-029 Shared package byte_fifo_pkg holds FRAME_BYTES_DEF=15, BYTE_W=8, FRAME_W=120 and the DEPTH default; the existing byte-to-frame FIFO uses the same constants.
REQ-030 One sub-module frame_ram (DEPTH x 120 bits: synchronous write, combinational read by pointer) holds the storage; pointers, counter, byte mux and flags live in the top module.
REQ-031 The byte select is a shift/mux on bidx with no 120-bit shift register per entry.

Verification
REQ-032 Reset, write 0x0F0E..0201 (bytes 01..0F), then rinc held for 15 cycles -> rdata 01,02,...,0F on consecutive cycles, rvalid=1 throughout, empty=1 after the last pop.
REQ-033 Write frames A (bytes 0x10..0x1E) and B (0x20..0x2E) -> full=1; a third winc -> ovf=1; then reading 30 bytes returns A then B unchanged.
REQ-034 rinc with empty=1 after reset -> rvalid=0, rdata=00, udf=1.
REQ-035 Alternate 3 write/read-all frame passes with DEPTH=2 -> pointer wrap, data intact, count never exceeds 2.
REQ-036 Full, reading byte 14 of frame A while winc=1 in the same cycle -> write dropped, ovf=1, count=1.
REQ-037 Assert rst after byte 7 of a frame -> next cycle empty=1, rvalid=0, and the following write/read returns byte 0 of the new frame first.
